// File: rtl/wbu_scoreboard.sv
// Write-back unit with register scoreboard.
// Merges the EXU and LSU result channels into a single regfile write port,
// one result per cycle, and tracks which architectural registers still have
// a write outstanding. Illegal WAW situations raise a sticky error flag.
module wbu_scoreboard #(
  parameter bit RR_EN = 1'b1  // 1: round-robin on conflict, 0: LSU always wins
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        exu_valid_i,
  output logic        exu_ready_o,
  input  logic [4:0]  exu_rd_i,
  input  logic        exu_wen_i,
  input  logic [31:0] exu_wdata_i,

  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,

  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  input  logic        iss_wen_i,

  output logic        reg_wen_o,
  output logic [4:0]  reg_dst_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] busy_o,
  output logic        retire_o,
  output logic        err_o
);

  // Arbitration: 1 in rr_q means the LSU is favoured on the next conflict.
  logic        rr_q, rr_d;
  logic        conflict;
  logic        exu_gnt, lsu_gnt;

  // Selected result for this cycle.
  logic        acc;
  logic [4:0]  acc_rd;
  logic        acc_wen;
  logic [31:0] acc_wdata;
  logic        acc_writes;

  // Registered write-back stage.
  logic        retire_q, retire_d;
  logic        reg_wen_q, reg_wen_d;
  logic [4:0]  reg_dst_q, reg_dst_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;

  // Scoreboard state.
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;
  logic        iss_set;

  // Grant is purely combinational from the two valids and the RR pointer.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    conflict = exu_valid_i && lsu_valid_i;
    exu_gnt  = exu_valid_i;
    lsu_gnt  = lsu_valid_i;
    if (conflict) begin
      lsu_gnt = RR_EN ? rr_q : 1'b1;
      exu_gnt = !lsu_gnt;
    end
  end

  // Nothing is accepted while reset is held, so a source never sees a
  // handshake for a result that the reset is about to discard.
  assign exu_ready_o = exu_gnt && rst_n_i;
  assign lsu_ready_o = lsu_gnt && rst_n_i;

  // Result mux: the granted channel feeds the write-back stage.
  always_comb begin
    acc        = exu_gnt || lsu_gnt;
    acc_rd     = lsu_gnt ? lsu_rd_i    : exu_rd_i;
    acc_wen    = lsu_gnt ? lsu_wen_i   : exu_wen_i;
    acc_wdata  = lsu_gnt ? lsu_wdata_i : exu_wdata_i;
    acc_writes = acc && acc_wen && (acc_rd != 5'd0);
  end

  // Next state of the write-back stage and the RR pointer.
  always_comb begin
    retire_d    = acc;
    reg_wen_d   = acc_writes;
    reg_dst_d   = acc ? acc_rd    : reg_dst_q;
    reg_wdata_d = acc ? acc_wdata : reg_wdata_q;
    rr_d        = rr_q;
    // After a conflict the loser gets priority on the next one.
    if (RR_EN && conflict) rr_d = exu_gnt;
  end

  // Scoreboard update: clear on regfile write, set on issue (set wins).
  always_comb begin
    iss_set = iss_valid_i && iss_wen_i && (iss_rd_i != 5'd0);
    busy_d  = busy_q;
    err_d   = err_q;
    if (reg_wen_q) busy_d[reg_dst_q] = 1'b0;
    if (iss_set) begin
      busy_d[iss_rd_i] = 1'b1;
      // WAW on issue: the previous write is still pending, even if it
      // retires at this very edge.
      if (busy_q[iss_rd_i]) err_d = 1'b1;
    end
    // A register write nobody issued for is still performed, but flagged.
    if (acc_writes && !busy_q[acc_rd]) err_d = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers; every flop, including the busy vector, clears on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst_n_i) begin
      rr_q        <= 1'b0;
      retire_q    <= 1'b0;
      reg_wen_q   <= 1'b0;
      reg_dst_q   <= 5'd0;
      reg_wdata_q <= 32'd0;
      busy_q      <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      retire_q    <= retire_d;
      reg_wen_q   <= reg_wen_d;
      reg_dst_q   <= reg_dst_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign retire_o    = retire_q;
  assign reg_wen_o   = reg_wen_q;
  assign reg_dst_o   = reg_dst_q;
  assign reg_wdata_o = reg_wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wbu_scoreboard.sv
// Self-checking bench for wbu_scoreboard: directed scenarios followed by
// randomized traffic; accepted results are checked by a scoreboard monitor.
module tb_wbu_scoreboard;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] d;
  } res_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wen;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  dst;
    logic [31:0] d;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        exu_valid_i = 1'b0, lsu_valid_i = 1'b0, iss_valid_i = 1'b0;
  logic [4:0]  exu_rd_i = '0, lsu_rd_i = '0, iss_rd_i = '0;
  logic        exu_wen_i = 1'b0, lsu_wen_i = 1'b0, iss_wen_i = 1'b0;
  logic [31:0] exu_wdata_i = '0, lsu_wdata_i = '0;

  logic        exu_ready_o, lsu_ready_o, reg_wen_o, retire_o, err_o;
  logic [4:0]  reg_dst_o;
  logic [31:0] reg_wdata_o, busy_o;

  logic        exu_ready0, lsu_ready0, reg_wen0, retire0, err0;
  logic [4:0]  reg_dst0;
  logic [31:0] reg_wdata0, busy0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state.
  exp_t        exp_q[$];
  logic [31:0] m_busy = '0;
  logic        m_err = 1'b0;
  logic        m_last_lsu = 1'b1;  // last conflict winner; EXU goes first
  logic        m_wb_v = 1'b0;
  logic [4:0]  m_wb_rd = '0;
  logic [4:0]  outst[$];
  exp_t        mon_x;

  wbu_scoreboard #(.RR_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready_o), .exu_rd_i(exu_rd_i),
    .exu_wen_i(exu_wen_i), .exu_wdata_i(exu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i),
    .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_wen_i(iss_wen_i),
    .reg_wen_o(reg_wen_o), .reg_dst_o(reg_dst_o), .reg_wdata_o(reg_wdata_o),
    .busy_o(busy_o), .retire_o(retire_o), .err_o(err_o)
  );

  // Fixed-priority instance, used for its arbitration and reset behaviour.
  wbu_scoreboard #(.RR_EN(1'b0)) dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .exu_valid_i(exu_valid_i), .exu_ready_o(exu_ready0), .exu_rd_i(exu_rd_i),
    .exu_wen_i(exu_wen_i), .exu_wdata_i(exu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready0), .lsu_rd_i(lsu_rd_i),
    .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_wen_i(iss_wen_i),
    .reg_wen_o(reg_wen0), .reg_dst_o(reg_dst0), .reg_wdata_o(reg_wdata0),
    .busy_o(busy0), .retire_o(retire0), .err_o(err0)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk_res(input logic v, input logic [4:0] rd,
                                  input logic wen, input logic [31:0] d);
    res_t x;
    x.v = v; x.rd = rd; x.wen = wen; x.d = d;
    return x;
  endfunction

  function automatic iss_t mk_iss(input logic [4:0] rd);
    iss_t x;
    x.v = 1'b1; x.rd = rd; x.wen = 1'b1;
    return x;
  endfunction

  // Scoreboard monitor: a result accepted in cycle N must show up in N+1.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc - 1) begin
        mon_x = exp_q.pop_front();
        check("retire", 32'(retire_o), 32'd1);
        check("reg_wen", 32'(reg_wen_o), 32'(mon_x.wen));
        check("reg_dst", 32'(reg_dst_o), 32'(mon_x.dst));
        check("reg_wdata", reg_wdata_o, mon_x.d);
      end else begin
        check("retire_idle", 32'(retire_o), 32'd0);
        check("reg_wen_idle", 32'(reg_wen_o), 32'd0);
      end
    end
  end

  // One clock cycle: check state, drive inputs, check grants, advance model.
  task automatic step(input res_t e, input res_t l, input iss_t s,
                      output logic eg, output logic lg);
    logic [31:0] nb;
    res_t        w;
    logic        acc, writes;
    exp_t        x;
    @(negedge clk_i);
    check("busy", busy_o, m_busy);
    check("err", 32'(err_o), 32'(m_err));
    exu_valid_i = e.v; exu_rd_i = e.rd; exu_wen_i = e.wen; exu_wdata_i = e.d;
    lsu_valid_i = l.v; lsu_rd_i = l.rd; lsu_wen_i = l.wen; lsu_wdata_i = l.d;
    iss_valid_i = s.v; iss_rd_i = s.rd; iss_wen_i = s.wen;
    #1;
    if (e.v && l.v) begin
      lg = !m_last_lsu;
      eg = m_last_lsu;
    end else begin
      eg = e.v;
      lg = l.v;
    end
    check("exu_ready", 32'(exu_ready_o), 32'(eg));
    check("lsu_ready", 32'(lsu_ready_o), 32'(lg));
    check("exu_ready_fixed", 32'(exu_ready0), 32'(e.v && !l.v));
    check("lsu_ready_fixed", 32'(lsu_ready0), 32'(l.v));
    acc = eg || lg;
    w = lg ? l : e;
    writes = acc && w.wen && (w.rd != 5'd0);
    if (acc) begin
      x.cyc = cyc; x.wen = writes; x.dst = w.rd; x.d = w.d;
      exp_q.push_back(x);
    end
    nb = m_busy;
    if (m_wb_v) nb[m_wb_rd] = 1'b0;
    if (s.v && s.wen && s.rd != 5'd0) begin
      if (m_busy[s.rd]) m_err = 1'b1;
      nb[s.rd] = 1'b1;
    end
    if (writes && !m_busy[w.rd]) m_err = 1'b1;
    m_wb_v = writes;
    m_wb_rd = w.rd;
    if (e.v && l.v) m_last_lsu = lg;
    m_busy = nb;
  endtask

  task automatic idle(input int n);
    logic eg, lg;
    for (int i = 0; i < n; i++) step('0, '0, '0, eg, lg);
  endtask

  // Reset asserted mid-cycle; outputs of both instances must drop at once.
  task automatic do_reset();
    rst_n_i = 1'b0;
    exu_valid_i = 1'b1; lsu_valid_i = 1'b1; iss_valid_i = 1'b0;
    #1;
    check("rst_busy", busy_o, 32'd0);
    check("rst_reg_wen", 32'(reg_wen_o), 32'd0);
    check("rst_retire", 32'(retire_o), 32'd0);
    check("rst_reg_dst", 32'(reg_dst_o), 32'd0);
    check("rst_reg_wdata", reg_wdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_exu_ready", 32'(exu_ready_o), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready_o), 32'd0);
    check("rst_fixed_outs", {busy0[31:12], reg_wdata0[11:0]} | 32'(reg_dst0)
          | 32'({reg_wen0, retire0, err0, exu_ready0, lsu_ready0}), 32'd0);
    check("rst_fixed_busy_lo", 32'(busy0[11:0]), 32'd0);
    check("rst_fixed_wdata_hi", 32'(reg_wdata0[31:12]), 32'd0);
    exp_q.delete();
    outst.delete();
    m_busy = '0; m_err = 1'b0; m_last_lsu = 1'b1; m_wb_v = 1'b0; m_wb_rd = '0;
    exu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic new_res(output res_t x);
    x = '0;
    case ($urandom_range(0, 5))
      0, 1, 2: if (outst.size() != 0) x = mk_res(1'b1, outst.pop_front(), 1'b1, $urandom);
      3:       x = mk_res(1'b1, 5'($urandom_range(0, 31)), 1'b0, $urandom);
      4:       x = mk_res(1'b1, 5'd0, 1'b1, $urandom);
      default: x = '0;
    endcase
  endtask

  initial begin
    logic eg, lg;
    res_t pe, pl;
    iss_t s;
    logic [4:0] r;

    #3;
    do_reset();

    // Issue rd5, write it back from the EXU two cycles later.
    step('0, '0, mk_iss(5'd5), eg, lg);
    idle(1);
    step(mk_res(1'b1, 5'd5, 1'b1, 32'hDEADBEEF), '0, '0, eg, lg);
    idle(2);
    check("wb_busy5_clear", 32'(busy_o[5]), 32'd0);

    // Result to x0: retires without a register write or an error.
    step(mk_res(1'b1, 5'd0, 1'b1, 32'h1), '0, '0, eg, lg);
    idle(2);

    // Three cycles of conflict: EXU, LSU, EXU with round-robin.
    step('0, '0, mk_iss(5'd10), eg, lg);
    step('0, '0, mk_iss(5'd11), eg, lg);
    step('0, '0, mk_iss(5'd12), eg, lg);
    step(mk_res(1'b1, 5'd10, 1'b1, 32'hA0A0_0010), mk_res(1'b1, 5'd11, 1'b1, 32'hB0B0_0011), '0, eg, lg);
    step(mk_res(1'b1, 5'd12, 1'b1, 32'hA0A0_0012), mk_res(1'b1, 5'd11, 1'b1, 32'hB0B0_0011), '0, eg, lg);
    step(mk_res(1'b1, 5'd12, 1'b1, 32'hA0A0_0012), mk_res(1'b1, 5'd0, 1'b0, 32'h5555_0000), '0, eg, lg);
    step('0, mk_res(1'b1, 5'd0, 1'b0, 32'h5555_0000), '0, eg, lg);
    idle(3);
    check("rr_busy_clear", busy_o, 32'd0);

    // Re-issue rd7 at the edge where its write-back clears it.
    step('0, '0, mk_iss(5'd7), eg, lg);
    step(mk_res(1'b1, 5'd7, 1'b1, 32'h0000_0777), '0, '0, eg, lg);
    step('0, '0, mk_iss(5'd7), eg, lg);
    idle(2);
    check("waw_clear_busy7", 32'(busy_o[7]), 32'd1);
    check("waw_clear_err", 32'(err_o), 32'd1);

    // Write to a register that was never issued: flagged, still written.
    @(negedge clk_i); #1;
    do_reset();
    step(mk_res(1'b1, 5'd9, 1'b1, 32'h0000_1234), '0, '0, eg, lg);
    idle(2);
    check("unissued_err", 32'(err_o), 32'd1);

    // Double issue of rd3: sticky error until reset.
    @(negedge clk_i); #1;
    do_reset();
    step('0, '0, mk_iss(5'd3), eg, lg);
    step('0, '0, mk_iss(5'd3), eg, lg);
    idle(4);
    check("dbl_issue_err", 32'(err_o), 32'd1);
    check("dbl_issue_busy3", 32'(busy_o[3]), 32'd1);

    // Reset mid-cycle with registers pending and a write in progress.
    @(negedge clk_i); #1;
    do_reset();
    step('0, '0, mk_iss(5'd5), eg, lg);
    step('0, '0, mk_iss(5'd7), eg, lg);
    step(mk_res(1'b1, 5'd5, 1'b1, 32'hCAFE_0005), '0, '0, eg, lg);
    step('0, '0, '0, eg, lg);
    check("pre_rst_busy", busy_o, 32'h0000_00A0);
    check("pre_rst_reg_wen", 32'(reg_wen_o), 32'd1);
    #1;
    do_reset();

    // Randomized legal traffic.
    pe = '0;
    pl = '0;
    for (int n = 0; n < 600; n++) begin
      s = '0;
      r = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 2) == 0 && !m_busy[r]) s = mk_iss(r);
      if (!pe.v && $urandom_range(0, 1) == 1) new_res(pe);
      if (!pl.v && $urandom_range(0, 1) == 1) new_res(pl);
      step(pe, pl, s, eg, lg);
      if (s.v) outst.push_back(r);
      if (eg) pe = '0;
      if (lg) pl = '0;
    end
    for (int n = 0; n < 4 && (pe.v || pl.v); n++) begin
      step(pe, pl, '0, eg, lg);
      if (eg) pe = '0;
      if (lg) pl = '0;
    end
    idle(3);
    check("rand_pending_done", 32'(pe.v || pl.v), 32'd0);
    check("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("rand_err", 32'(err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wbu_scoreboard.md
WBU_SCOREBOARD -- requirements
Module: wbu_scoreboard

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning: 1 = round-robin arbitration on conflict, 0 = fixed LSU priority.
REQ-002 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have exu_valid_i  input  1  EXU result valid.
REQ-005 SHALL have exu_ready_o  output  1  EXU result accepted this cycle.
REQ-006 SHALL have exu_rd_i  input  5  EXU destination register.
REQ-007 SHALL have exu_wen_i  input  1  EXU result writes a register.
REQ-008 SHALL have exu_wdata_i  input  32  EXU result data.
REQ-009 SHALL have lsu_valid_i  input  1, lsu_ready_o  output  1, lsu_rd_i  input  5, lsu_wen_i  input  1, lsu_wdata_i  input  32; same meanings for the LSU channel.
REQ-010 SHALL have iss_valid_i  input  1  instruction issued this cycle.
REQ-011 SHALL have iss_rd_i  input  5  destination of the issued instruction.
REQ-012 SHALL have iss_wen_i  input  1  issued instruction writes rd.
REQ-013 SHALL have reg_wen_o  output  1, reg_dst_o  output  5, reg_wdata_o  output  32  regfile write port.
REQ-014 SHALL have busy_o  output  32  per-register pending-write bits.
REQ-015 SHALL have retire_o  output  1  one-cycle pulse per accepted result.
REQ-016 SHALL have err_o  output  1  sticky WAW-issue error flag.

Function
REQ-017 SHALL accept at most one result per cycle; a channel's ready_o is high only in a cycle where that channel is granted.
REQ-018 Grant SHALL be combinational from the valids: a single valid is granted; if both are valid, RR_EN=1 grants the channel not granted on the last conflict (EXU first after reset), and RR_EN=0 grants LSU.
REQ-019 ready_o SHALL not depend on ready_o; a valid request that is not granted SHALL remain pending, and its payload must be held stable by the source.
REQ-020 An accepted result SHALL appear on the outputs exactly one cycle later (registered): reg_wen_o = wen && rd!=0, reg_dst_o = rd, reg_wdata_o = wdata, retire_o = 1.
REQ-021 reg_wen_o and retire_o SHALL be high only for the single cycle after acceptance; with no acceptance, both are 0 and reg_dst_o / reg_wdata_o hold their last values.
REQ-022 A result with wen=0 or rd=0 SHALL still pulse retire_o but not reg_wen_o.
REQ-023 Busy bit rd SHALL be set at the edge where iss_valid_i && iss_wen_i && iss_rd_i!=0.
REQ-024 Busy bit rd SHALL clear at the edge where reg_wen_o=1 with reg_dst_o=rd, which is the same edge at which the regfile writes rd.
REQ-025 If a set and a clear target the same rd at one edge, set SHALL win.
REQ-026 busy_o[0] SHALL be constant 0.
REQ-027 No forwarding is provided: busy_o drops in the cycle after the regfile write, so the new value is readable combinationally from the regfile in that cycle.
REQ-028 An issue to an rd whose busy bit is already 1 (including one clearing at the same edge) SHALL set err_o, which stays 1 until reset; the busy bit stays 1.
REQ-029 An accepted result whose rd is not busy with wen=1 and rd!=0 SHALL also set err_o and SHALL still be written.

Reset
REQ-030 While rst_n_i=0, asynchronously: busy_o=0, reg_wen_o=0, retire_o=0, reg_dst_o=0, reg_wdata_o=0, err_o=0, RR pointer=EXU-first.
REQ-031 ready_o outputs SHALL be 0 while rst_n_i=0; an in-flight result is discarded on reset mid-operation.
REQ-032 Reset deassertion SHALL be synchronised by the integrator; first acceptance is possible on the first edge after release.

Verification
REQ-033 Issue rd=5 (cycle 0); EXU sends rd=5, data 0xDEADBEEF (cycle 2) -> exu_ready_o=1 in cycle 2; cycle 3 shows reg_wen_o=1, reg_dst_o=5, reg_wdata_o=0xDEADBEEF; busy_o[5] 1 from cycle 1 through cycle 3, 0 from cycle 4.
REQ-034 Both channels valid for 3 cycles with RR_EN=1 -> grants EXU, LSU, EXU; retire_o pulses 3 times; with RR_EN=0 -> LSU granted in all 3 cycles.
REQ-035 EXU result rd=0, wen=1, data 0x1 -> retire_o=1, reg_wen_o=0, busy_o unchanged, err_o=0.
REQ-036 Issue rd=7 in the same cycle that reg_wen_o=1 with reg_dst_o=7 -> busy_o[7]=1 afterwards and err_o=1.
REQ-037 Assert rst_n_i low mid-cycle while busy_o=0x0000_00A0 and reg_wen_o=1 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-038 Issue rd=3 twice without an intervening writeback -> err_o=1 sticky until reset, busy_o[3]=1.
